// File: rtl/rename_issue_unit_if.sv
// rtl/rename_issue_unit_if.sv - decode-side and D/E-side handshake bundle for the rename/issue unit
interface rename_issue_unit_if #(
  parameter int WORD_SIZE       = 32,
  parameter int ROB_ENTRY_WIDTH = 3,
  parameter int REG_IDX_W       = 5
);
  logic                       in_valid;
  logic                       in_ready;
  logic [REG_IDX_W-1:0]       in_rs1;
  logic [REG_IDX_W-1:0]       in_rs2;
  logic [REG_IDX_W-1:0]       in_rd;
  logic                       in_uses_rs1;
  logic                       in_uses_rs2;
  logic                       in_writes_rd;
  logic                       out_valid;
  logic                       out_ready;
  logic [WORD_SIZE-1:0]       out_s1_data;
  logic [WORD_SIZE-1:0]       out_s2_data;
  logic [ROB_ENTRY_WIDTH-1:0] out_rob_id;
  logic [REG_IDX_W-1:0]       out_rd;

  modport master (
    output in_valid, in_rs1, in_rs2, in_rd, in_uses_rs1, in_uses_rs2, in_writes_rd, out_ready,
    input  in_ready, out_valid, out_s1_data, out_s2_data, out_rob_id, out_rd
  );

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_rd, in_uses_rs1, in_uses_rs2, in_writes_rd, out_ready,
    output in_ready, out_valid, out_s1_data, out_s2_data, out_rob_id, out_rd
  );
endinterface

// File: rtl/rename_issue_unit.sv
// rtl/rename_issue_unit.sv - register alias table, operand forwarding and registered issue slot
module rename_issue_unit #(
  parameter int WORD_SIZE       = 32,
  parameter int ARCH_REGS       = 32,
  parameter int ROB_ENTRY_WIDTH = 3,
  parameter int NUM_BYPASS      = 6,
  parameter int REG_IDX_W       = $clog2(ARCH_REGS)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  rename_issue_unit_if.slave                    bus,
  input  logic [WORD_SIZE-1:0]                  rf_s1_data,
  input  logic [WORD_SIZE-1:0]                  rf_s2_data,
  output logic [ROB_ENTRY_WIDTH-1:0]            rob_s1_id,
  output logic [ROB_ENTRY_WIDTH-1:0]            rob_s2_id,
  input  logic [WORD_SIZE-1:0]                  rob_s1_data,
  input  logic [WORD_SIZE-1:0]                  rob_s2_data,
  input  logic                                  rob_s1_valid,
  input  logic                                  rob_s2_valid,
  input  logic [ROB_ENTRY_WIDTH-1:0]            rob_alloc_id,
  input  logic                                  rob_full,
  output logic                                  rob_alloc,
  input  logic [NUM_BYPASS*WORD_SIZE-1:0]       bypass_data,
  input  logic [NUM_BYPASS*ROB_ENTRY_WIDTH-1:0] bypass_rob_id,
  input  logic [NUM_BYPASS-1:0]                 bypass_en,
  input  logic                                  commit,
  input  logic [REG_IDX_W-1:0]                  commit_rd,
  input  logic [ROB_ENTRY_WIDTH-1:0]            commit_rob_id,
  input  logic                                  flush,
  output logic [15:0]                           stall_cycles
);

  logic                       r_rat_valid [ARCH_REGS];
  logic [ROB_ENTRY_WIDTH-1:0] r_rat_id    [ARCH_REGS];

  logic                       r_out_valid;
  logic [WORD_SIZE-1:0]       r_out_s1;
  logic [WORD_SIZE-1:0]       r_out_s2;
  logic [ROB_ENTRY_WIDTH-1:0] r_out_rob_id;
  logic [REG_IDX_W-1:0]       r_out_rd;
  logic [15:0]                r_stall;

  logic                       w_s1_mapped;
  logic                       w_s2_mapped;
  logic [WORD_SIZE:0]         w_s1_res;
  logic [WORD_SIZE:0]         w_s2_res;
  logic                       w_fire;

  // Returns {ready, data}. Bypass is scanned high to low so the lowest-index
  // matching channel is the last writer and therefore wins.
  function automatic logic [WORD_SIZE:0] resolve(
    input logic                       uses,
    input logic                       mapped,
    input logic [ROB_ENTRY_WIDTH-1:0] id,
    input logic [WORD_SIZE-1:0]       rf_data,
    input logic [WORD_SIZE-1:0]       rob_data,
    input logic                       rob_valid
  );
    logic [WORD_SIZE:0] res;
    res = '0;
    if (!uses) begin
      res = {1'b1, {WORD_SIZE{1'b0}}};
    end else if (!mapped) begin
      res = {1'b1, rf_data};
    end else begin
      if (rob_valid) res = {1'b1, rob_data};
      for (int k = NUM_BYPASS - 1; k >= 0; k--) begin
        if (bypass_en[k] && (bypass_rob_id[k*ROB_ENTRY_WIDTH +: ROB_ENTRY_WIDTH] == id))
          res = {1'b1, bypass_data[k*WORD_SIZE +: WORD_SIZE]};
      end
    end
    return res;
  endfunction

  assign w_s1_mapped = (bus.in_rs1 != '0) && r_rat_valid[bus.in_rs1];
  assign w_s2_mapped = (bus.in_rs2 != '0) && r_rat_valid[bus.in_rs2];
  assign rob_s1_id   = w_s1_mapped ? r_rat_id[bus.in_rs1] : '0;
  assign rob_s2_id   = w_s2_mapped ? r_rat_id[bus.in_rs2] : '0;

  // Operand resolution for both sources against RF, bypass network and ROB
  always_comb begin
    w_s1_res = resolve(bus.in_uses_rs1, w_s1_mapped, rob_s1_id, rf_s1_data, rob_s1_data, rob_s1_valid);
    w_s2_res = resolve(bus.in_uses_rs2, w_s2_mapped, rob_s2_id, rf_s2_data, rob_s2_data, rob_s2_valid);
  end

  assign w_fire = bus.in_valid && w_s1_res[WORD_SIZE] && w_s2_res[WORD_SIZE]
                  && !(bus.in_writes_rd && rob_full)
                  && (!r_out_valid || bus.out_ready) && !flush;

  assign bus.in_ready    = w_fire;
  assign rob_alloc       = w_fire && bus.in_writes_rd;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_s1_data = r_out_s1;
  assign bus.out_s2_data = r_out_s2;
  assign bus.out_rob_id  = r_out_rob_id;
  assign bus.out_rd      = r_out_rd;
  assign stall_cycles    = r_stall;

  // Output slot: load on fire, hold until accepted, drop on flush
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid  <= 1'b0;
      r_out_s1     <= '0;
      r_out_s2     <= '0;
      r_out_rob_id <= '0;
      r_out_rd     <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_fire) begin
      r_out_valid  <= 1'b1;
      r_out_s1     <= w_s1_res[WORD_SIZE-1:0];
      r_out_s2     <= w_s2_res[WORD_SIZE-1:0];
      r_out_rob_id <= bus.in_writes_rd ? rob_alloc_id : '0;
      r_out_rd     <= bus.in_rd;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // RAT update: commit clears a matching mapping, a rename issued later in
  // the block overrides it when both hit the same register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        r_rat_valid[i] <= 1'b0;
        r_rat_id[i]    <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < ARCH_REGS; i++) r_rat_valid[i] <= 1'b0;
    end else begin
      if (commit && r_rat_valid[commit_rd] && (r_rat_id[commit_rd] == commit_rob_id))
        r_rat_valid[commit_rd] <= 1'b0;
      if (w_fire && bus.in_writes_rd && (bus.in_rd != '0)) begin
        r_rat_valid[bus.in_rd] <= 1'b1;
        r_rat_id[bus.in_rd]    <= rob_alloc_id;
      end
    end
  end

  // Saturating count of cycles an offered instruction was held back
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall <= '0;
    end else if (bus.in_valid && !w_fire && !flush && (r_stall != 16'hFFFF)) begin
      r_stall <= r_stall + 16'd1;
    end
  end

endmodule

// File: doc/rename_issue_unit.md
Name: rename_issue_unit

Overview:
- Parametrised successor of the decode-stage rename/forward logic.
- Holds a register alias table (RAT) mapping architectural registers to in-flight ROB ids, and resolves two source operands from the RF, the ROB, or any of NUM_BYPASS bypass channels.
- Allocates ROB entries and hands operands to the D/E register through a registered valid/ready output slot.
- Sits between the decoder/register file and the D/E pipeline register; the decoder is external.

Parameters:
- WORD_SIZE, 32, operand data width.
- ARCH_REGS, 32, number of architectural registers; register 0 is hard-wired and never renamed.
- ROB_ENTRY_WIDTH, 3, ROB id width.
- NUM_BYPASS, 6, number of bypass channels (ALU, ALU-WB, MEM, MEM-WB, MUL, MUL-WB by default).
- REG_IDX_W, $clog2(ARCH_REGS), architectural index width (derived).

Ports:
- clk  in  1  clock; one clock domain.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  decoded instruction present.
- in_ready  out  1  instruction accepted this cycle.
- in_rs1, in_rs2, in_rd  in  REG_IDX_W each  source and destination indices.
- in_uses_rs1, in_uses_rs2, in_writes_rd  in  1 each  operand/destination usage flags.
- rf_s1_data, rf_s2_data  in  WORD_SIZE  combinational RF read data for in_rs1/in_rs2.
- rob_s1_id, rob_s2_id  out  ROB_ENTRY_WIDTH  ROB lookup ids (RAT mapping of rs1/rs2).
- rob_s1_data, rob_s2_data  in  WORD_SIZE  ROB result for the looked-up id.
- rob_s1_valid, rob_s2_valid  in  1  ROB result present.
- rob_alloc_id  in  ROB_ENTRY_WIDTH  next free ROB id.
- rob_full  in  1  no ROB entry free.
- rob_alloc  out  1  consume rob_alloc_id this cycle.
- bypass_data  in  NUM_BYPASS*WORD_SIZE  packed bypass values; channel k occupies bits [k*WORD_SIZE +: WORD_SIZE].
- bypass_rob_id  in  NUM_BYPASS*ROB_ENTRY_WIDTH  packed producer ids.
- bypass_en  in  NUM_BYPASS  per-channel valid.
- commit  in  1  ROB head retires.
- commit_rd  in  REG_IDX_W  retiring destination.
- commit_rob_id  in  ROB_ENTRY_WIDTH  retiring id.
- flush  in  1  mispredict/jump taken; squash.
- out_valid  out  1  output slot full.
- out_ready  in  1  D/E register accepts.
- out_s1_data, out_s2_data  out  WORD_SIZE  resolved operands.
- out_rob_id  out  ROB_ENTRY_WIDTH  allocated id (0 if !in_writes_rd).
- out_rd  out  REG_IDX_W  destination.
- stall_cycles  out  16  saturating count of cycles with in_valid && !in_ready.

Behaviour:
- Reset (rst=0, async): all RAT valid bits cleared, ids 0; out_valid=0; out_* data 0; stall_cycles=0. Combinational outputs follow their equations.
- RAT entry = {valid, rob_id}. Register 0 always reads as unmapped.
- Operand resolution per source, priority order:
  - not used -> ready, data 0;
  - unmapped -> ready, RF data;
  - lowest-index bypass channel with bypass_en && id match -> ready, bypass data;
  - rob_sX_valid -> ready, ROB data;
  - otherwise not ready.
- rob_sX_id = RAT id (0 if unmapped).
- fire = in_valid && both sources ready && !(in_writes_rd && rob_full) && (!out_valid || out_ready) && !flush.
- in_ready = fire. rob_alloc = fire && in_writes_rd.
- Latency 1: on fire the output slot loads operands, rd and id; out_valid=1. out_valid holds, with data stable, until out_ready; if out_ready && !fire, out_valid clears.
- On fire with in_writes_rd && in_rd!=0: RAT[in_rd] <= {1, rob_alloc_id}. Sources read the pre-update mapping (rs==rd in the same instruction gets the old producer).
- Commit: clears RAT[commit_rd] only if valid and id==commit_rob_id; a stale commit (id mismatch) leaves the newer mapping.
- Same-cycle rename and commit to the same register: rename wins.
- flush (highest priority): all RAT valid cleared, out_valid cleared next edge, fire forced 0; a commit in the same cycle is irrelevant.
- stall_cycles increments when in_valid && !in_ready && !flush; saturates at 16'hFFFF.

Test Plan:
- Reset, then in_valid, rs1=3, rs2=4 unmapped, rf data 0x11/0x22, rd=5, rob_alloc_id=2 -> next cycle out_valid=1, s1=0x11, s2=0x22, out_rob_id=2; RAT[5]={1,2}.
- Then rs1=5, bypass_en[4]=1, bypass_rob_id[4]=2, data 0xAB, bypass_en[1] also matching with 0xCD -> s1=0xCD (lowest index wins).
- rs1=5 mapped to id 2, no bypass, rob_s1_valid=0 -> in_ready=0 and stall_cycles increments each cycle; raise rob_s1_valid with data 0x77 -> fire, s1=0x77.
- out_ready=0 with out_valid=1 -> in_ready=0 and out data held; rob_full=1 with in_writes_rd=1 -> no fire, rob_alloc=0.
- Rename r5->id 6 while commit r5, id 2 in the same cycle -> RAT[5]={1,6}; later commit r5, id 6 -> RAT[5] unmapped.
- flush with mapped r5/r7 and out_valid=1 -> next cycle all unmapped, out_valid=0; rst low mid-stall -> stall_cycles=0 immediately.
